// File: rtl/button_debounce.sv
// Push-button synchronizer/debouncer with press, release and long-press events.
// Optional long-press detection is enabled by defining BTN_LONG_PRESS_EN.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned LONG_CYCLES     = 33554432
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_btn,
    output logic       out_level,
    output logic       out_press,
    output logic       out_release,
    output logic       out_long,
    output logic [7:0] out_presses
);

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned CNT_MAX = (LONG_CYCLES > DEBOUNCE_CYCLES) ? LONG_CYCLES : DEBOUNCE_CYCLES;
    localparam int unsigned HW      = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
`else
    localparam int unsigned CNT_MAX = DEBOUNCE_CYCLES;
`endif
    localparam int unsigned CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam bit DEB_ONE = (DEBOUNCE_CYCLES == 1);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_check
        $error("button_debounce: illegal DEBOUNCE_CYCLES/LONG_CYCLES");
    end

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REL_WAIT_S
`ifdef BTN_LONG_PRESS_EN
        , LONG_HELD,
        REL_WAIT_L
`endif
    } state_t;

    state_t          state, state_n;
    logic [1:0]      sync_q;
    logic            s;
    logic [CW-1:0]   cnt, cnt_n;
    logic            press_n, release_n;
`ifdef BTN_LONG_PRESS_EN
    logic [HW-1:0]   hold, hold_n;
    logic            long_n;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[0], in_btn};
    end
    assign s = sync_q[1];

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
`ifdef BTN_LONG_PRESS_EN
        hold_n    = hold;
        long_n    = 1'b0;
`endif
        unique case (state)
            IDLE: if (s) begin
                if (DEB_ONE) begin
                    state_n = PRESSED;
                    press_n = 1'b1;
`ifdef BTN_LONG_PRESS_EN
                    hold_n  = '0;
`endif
                end else begin
                    state_n = PRESS_WAIT;
                    cnt_n   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                    press_n = 1'b1;
`ifdef BTN_LONG_PRESS_EN
                    hold_n  = '0;
`endif
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            // The zero that leaves PRESSED counts as the first release sample.
            PRESSED: begin
                if (!s) begin
                    if (DEB_ONE) begin
                        state_n   = IDLE;
                        release_n = 1'b1;
                    end else begin
                        state_n = REL_WAIT_S;
                        cnt_n   = CW'(1);
                    end
                end
`ifdef BTN_LONG_PRESS_EN
                else if (hold == HOLD_LAST) begin
                    state_n = LONG_HELD;
                    cnt_n   = '0;
                    long_n  = 1'b1;
                end else begin
                    hold_n = hold + HW'(1);
                end
`endif
            end
            REL_WAIT_S: begin
                if (s) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`ifdef BTN_LONG_PRESS_EN
            LONG_HELD: if (!s) begin
                if (DEB_ONE) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                end else begin
                    state_n = REL_WAIT_L;
                    cnt_n   = CW'(1);
                end
            end
            REL_WAIT_L: begin
                if (s) begin
                    state_n = LONG_HELD;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`endif
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            out_level   <= 1'b0;
            out_press   <= 1'b0;
            out_release <= 1'b0;
            out_presses <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            out_level   <= (state_n != IDLE) && (state_n != PRESS_WAIT);
            out_press   <= press_n;
            out_release <= release_n;
            if (press_n) out_presses <= out_presses + 8'd1;
        end
    end

`ifdef BTN_LONG_PRESS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold     <= '0;
            out_long <= 1'b0;
        end else begin
            hold     <= hold_n;
            out_long <= long_n;
        end
    end
`else
    assign out_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with an event scoreboard keyed on clock edge numbers.
module tb_button_debounce;
    localparam int unsigned D = 4;
    localparam int unsigned L = 20;
    localparam logic [1:0] EV_PRESS = 2'd1;
    localparam logic [1:0] EV_REL   = 2'd2;
    localparam logic [1:0] EV_LONG  = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        int         edge_n;
        logic [7:0] presses;
        logic       level;
    } ev_t;

    logic       clock, reset, in_btn;
    logic       out_level, out_press, out_release, out_long;
    logic [7:0] out_presses;

    ev_t        q[$];
    ev_t        mon_e;
    logic [1:0] mon_kind;
    int         edge_no = -1;
    int         total   = 0;
    int         passed  = 0;
    logic [7:0] exp_presses;
    int         t0;

    button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_btn      (in_btn),
        .out_level   (out_level),
        .out_press   (out_press),
        .out_release (out_release),
        .out_long    (out_long),
        .out_presses (out_presses)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) edge_no++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic expect_ev(input logic [1:0] k, input int e);
        ev_t v;
        v.kind    = k;
        v.edge_n  = e;
        v.presses = exp_presses;
        v.level   = (k != EV_REL);
        q.push_back(v);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 64'(q.size()), 64'd0);
    endtask

    // Every event pulse is matched against the next expected event: kind, edge, count, level.
    always @(negedge clock) begin
        if (reset === 1'b1 && (out_press || out_release || out_long)) begin
            mon_kind = out_press ? EV_PRESS : (out_release ? EV_REL : EV_LONG);
            check("single_event", 64'($countones({out_press, out_release, out_long})), 64'd1);
            if (q.size() == 0) begin
                check($sformatf("unexpected_event_at_edge%0d", edge_no), 64'(mon_kind), 64'd0);
            end else begin
                mon_e = q.pop_front();
                check($sformatf("event_kind%0d_edge%0d", mon_e.kind, mon_e.edge_n),
                      {mon_kind, edge_no, out_presses, out_level},
                      {mon_e.kind, mon_e.edge_n, mon_e.presses, mon_e.level});
            end
        end
    end

    initial begin
        reset       = 1'b0;
        in_btn      = 1'b0;
        exp_presses = 8'd0;
        repeat (3) @(negedge clock);
        check("rst_level",   64'(out_level),   64'd0);
        check("rst_press",   64'(out_press),   64'd0);
        check("rst_release", 64'(out_release), 64'd0);
        check("rst_long",    64'(out_long),    64'd0);
        check("rst_presses", 64'(out_presses), 64'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Clean press held 40 cycles, then clean release
        in_btn = 1'b1;
        t0 = edge_no + 1;
        exp_presses++;
        expect_ev(EV_PRESS, t0 + D + 1);
`ifdef BTN_LONG_PRESS_EN
        expect_ev(EV_LONG, t0 + D + 1 + L);
`endif
        repeat (10) @(negedge clock);
        check("held_level",   64'(out_level),   64'd1);
        check("held_presses", 64'(out_presses), 64'd1);
        repeat (30) @(negedge clock);
        in_btn = 1'b0;
        t0 = edge_no + 1;
        expect_ev(EV_REL, t0 + D + 1);
        drain("drain_long_press", 30);
        check("released_level", 64'(out_level), 64'd0);

        // Bounce: three highs then a low never reaches the debounce count
        for (int i = 0; i < 6; i++) begin
            in_btn = 1'b1;
            repeat (3) @(negedge clock);
            in_btn = 1'b0;
            @(negedge clock);
        end
        repeat (12) @(negedge clock);
        check("bounce_level",   64'(out_level),   64'd0);
        check("bounce_presses", 64'(out_presses), 64'(exp_presses));
        check("bounce_no_events", 64'(q.size()), 64'd0);

        // Two-cycle release glitch while held (LONG_HELD, or PRESSED without long-press)
        in_btn = 1'b1;
        t0 = edge_no + 1;
        exp_presses++;
        expect_ev(EV_PRESS, t0 + D + 1);
`ifdef BTN_LONG_PRESS_EN
        expect_ev(EV_LONG, t0 + D + 1 + L);
`endif
        repeat (30) @(negedge clock);
        in_btn = 1'b0;
        repeat (2) @(negedge clock);
        in_btn = 1'b1;
        repeat (4) @(negedge clock);
        check("glitch_level", 64'(out_level), 64'd1);
        repeat (6) @(negedge clock);
        in_btn = 1'b0;
        t0 = edge_no + 1;
        expect_ev(EV_REL, t0 + D + 1);
        drain("drain_glitch", 30);

        // Reset during PRESS_WAIT with the button still held
        in_btn = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_level",   64'(out_level),   64'd0);
        check("midrst_pulses",  64'({out_press, out_release, out_long}), 64'd0);
        check("midrst_presses", 64'(out_presses), 64'd0);
        exp_presses = 8'd0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        t0 = edge_no + 1;
        exp_presses++;
        expect_ev(EV_PRESS, t0 + D + 1);
        repeat (10) @(negedge clock);
        in_btn = 1'b0;
        t0 = edge_no + 1;
        expect_ev(EV_REL, t0 + D + 1);
        drain("drain_after_reset", 30);

        // 255 further presses bring the count to 256, which wraps to 0
        for (int i = 0; i < 255; i++) begin
            in_btn = 1'b1;
            t0 = edge_no + 1;
            exp_presses++;
            expect_ev(EV_PRESS, t0 + D + 1);
            repeat (8) @(negedge clock);
            in_btn = 1'b0;
            t0 = edge_no + 1;
            expect_ev(EV_REL, t0 + D + 1);
            repeat (8) @(negedge clock);
        end
        drain("drain_wrap", 30);
        check("wrap_presses", 64'(out_presses), 64'd0);

        repeat (20) @(negedge clock);
        check("final_level", 64'(out_level), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/button_debounce.md
# button_debounce

Input-side companion to the LED blinker: samples one asynchronous push-button pin, synchronizes and debounces it, and emits single-cycle press, release and long-press events plus a debounced level and a wrapping press count. Sits between the board pin and the fabric logic that consumes user input, such as mode selection for LED patterns. Fully synchronous to `clock` apart from the asynchronous reset.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 65536: consecutive identical synchronized samples required to accept a level change. Must be ≥1.
- `LONG_CYCLES`, 33554432: consecutive pressed samples after the press is accepted before a long-press event. Must be > `DEBOUNCE_CYCLES`.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-low. Low forces reset immediately; release is sampled on `clock`.
- `in_btn` in 1: raw button, active-high, asynchronous to `clock`.
- `out_level` out 1: debounced level; 1 = pressed.
- `out_press` out 1: one-cycle pulse when a press is accepted.
- `out_release` out 1: one-cycle pulse when a release is accepted.
- `out_long` out 1: one-cycle pulse when a long press is detected.
- `out_presses` out 8: count of accepted presses; wraps from 255 to 0.

## Operation
- Two-flop synchronizer on `in_btn` produces `s`. All decisions use `s` only.
- One shared counter `cnt`, width clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)+1). Every state change clears `cnt`.
- FSM states and transitions:
  - IDLE: if `s`=1 → PRESS_WAIT with `cnt`=1.
  - PRESS_WAIT: if `s`=0 → IDLE. If `s`=1 and `cnt`+1 == DEBOUNCE_CYCLES → PRESSED, and pulse `out_press`. Otherwise `cnt`++. With DEBOUNCE_CYCLES=1, IDLE goes straight to PRESSED.
  - PRESSED: hold counter counts `s`=1 cycles. When it reaches LONG_CYCLES → LONG_HELD and pulse `out_long`. If `s`=0 → REL_WAIT_S.
  - LONG_HELD: if `s`=0 → REL_WAIT_L.
  - REL_WAIT_S / REL_WAIT_L: count `s`=0 samples. After DEBOUNCE_CYCLES consecutive zeros → IDLE and pulse `out_release`. If `s`=1 first, return to PRESSED or LONG_HELD respectively.
- The PRESSED hold count is preserved across a bounced release. Use a separate saved value or a dedicated hold counter. It is not cleared by a REL_WAIT_S excursion.
- `out_level` = 1 in PRESSED, LONG_HELD, REL_WAIT_S and REL_WAIT_L; 0 otherwise.
- `out_presses` increments in the same cycle `out_press` is asserted.
- Event outputs are registered. At most one event pulse is high in any cycle. No event repeats without an intervening release.

## Timing
- Reset (`reset`=0) values:
  - outputs: `out_level`, `out_press`, `out_release` and `out_long` = 0; `out_presses` = 0.
  - internal: synchronizer flops = 0; FSM = IDLE; counters = 0.
- Press latency: `in_btn` rises before edge 0 and stays high. `out_press` and `out_level` go high after edge DEBOUNCE_CYCLES+1. `out_press` stays high for exactly one cycle.
- Release latency is symmetric: `out_release` goes high after edge DEBOUNCE_CYCLES+1 measured from the falling `in_btn`. `out_level` drops in the same cycle.
- Long press: `out_long` goes high LONG_CYCLES edges after `out_press`, if `s` stays 1.
- Glitches: any `s` pulse or gap shorter than DEBOUNCE_CYCLES produces no event and no level change.
- Reset mid-operation: aborts any count; no release event is issued.
- Button held through reset release: detected as a fresh press; `out_press` fires DEBOUNCE_CYCLES+1 edges after `reset` deasserts.

## Configuration
- `BTN_LONG_PRESS_EN` defined: LONG_HELD, REL_WAIT_L and `out_long` behave as specified above.
- Not defined:
  - LONG_HELD and REL_WAIT_L are not built, and no hold counting is done.
  - `out_long` is tied to 0.
  - PRESSED exits only via REL_WAIT_S.
  - LONG_CYCLES is ignored, and the counter width is clog2(DEBOUNCE_CYCLES+1).

## Test plan
- Clean press with DEBOUNCE_CYCLES=4, LONG_CYCLES=20: `in_btn`=1 from edge 0 → `out_press` high only in the cycle after edge 5; `out_presses` = 1; `out_level` = 1.
- Bounce with DEBOUNCE_CYCLES=4: `in_btn` pattern 1,1,1,0,1,1,1,0 repeated, then a clean release → no events; `out_level` = 0; `out_presses` = 0.
- Long press with DEBOUNCE_CYCLES=4, LONG_CYCLES=20: hold for 40 cycles → `out_press`, then `out_long` 20 edges later, then `out_release` after release. Without the macro: no `out_long`.
- Release bounce during LONG_HELD: a 2-cycle low glitch → returns to LONG_HELD with no `out_release` and no second `out_long`.
- Wrap: 256 clean presses → `out_presses` reads 0 after the 256th `out_press`.
- Reset mid-press: assert `reset`=0 during PRESS_WAIT → all outputs 0 immediately. Button still held → `out_press` after edge DEBOUNCE_CYCLES+1 following deassertion.
